// File: rtl/motor_pkg.sv
// Shared definitions for the motor command path: widths, reserved tag and {dir,mag} packing.
// Used by motor_ramp and its per-channel ramp stage.
package motor_pkg;

    localparam int MAG_W  = 11;
    localparam int TAG_W  = 4;
    localparam int DATA_W = 24;
    localparam int CHAN_W = MAG_W + 1;

    // Tag used by the driver for counter-overflow reports; never accepted as a command.
    localparam logic [TAG_W-1:0] TAG_OVF = 4'hF;

    // Channel field offsets inside cmd_data / motor_data.
    localparam int CH0_LSB = 0;
    localparam int CH1_LSB = CHAN_W;

    typedef struct packed {
        logic             dir;
        logic [MAG_W-1:0] mag;
    } chan_t;

endpackage

// File: rtl/motor_ramp_chan.sv
// One motor channel: target register plus bounded-step ramp of the applied {dir,mag}.
// Optional clear input exists only when MOTOR_RAMP_ESTOP_EN is defined.
module motor_ramp_chan
    import motor_pkg::*;
#(
    parameter int unsigned STEP = 16
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  tick,
    input  logic  load,
    input  chan_t target,
`ifdef MOTOR_RAMP_ESTOP_EN
    input  logic  clear,
`endif
    output chan_t applied,
    output logic  changed,
    output logic  busy
);

    localparam logic [MAG_W-1:0]  STEP_M = MAG_W'(STEP);
    localparam logic [CHAN_W-1:0] STEP_W = CHAN_W'(STEP);

    chan_t              tgt_q, tgt_d;
    chan_t              app_q, app_d;
    chan_t              ramp;
    logic               busy_q, busy_d;
    logic [CHAN_W-1:0]  diff;

    always_comb begin
        tgt_d = tgt_q;
        if (load)
            tgt_d = target;

        // Ramp always works from the target held before this edge.
        ramp = app_q;
        diff = '0;
        if (app_q.mag != '0 && (tgt_q.mag == '0 || tgt_q.dir != app_q.dir)) begin
            ramp.mag = (app_q.mag > STEP_M) ? app_q.mag - STEP_M : '0;
        end else if (tgt_q.mag != '0 && tgt_q.dir != app_q.dir) begin
            ramp.dir = tgt_q.dir;
        end else if (tgt_q.mag > app_q.mag) begin
            diff     = {1'b0, tgt_q.mag} - {1'b0, app_q.mag};
            ramp.mag = (diff > STEP_W) ? app_q.mag + STEP_M : tgt_q.mag;
        end else begin
            diff     = {1'b0, app_q.mag} - {1'b0, tgt_q.mag};
            ramp.mag = (diff > STEP_W) ? app_q.mag - STEP_M : tgt_q.mag;
        end

        app_d = tick ? ramp : app_q;

`ifdef MOTOR_RAMP_ESTOP_EN
        if (clear) begin
            tgt_d.mag = '0;
            app_d.mag = '0;
        end
`endif

        changed = (app_d != app_q);
        busy_d  = (tgt_d.mag == '0) ? (app_d.mag != '0) : (app_d != tgt_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgt_q  <= '0;
            app_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            tgt_q  <= tgt_d;
            app_q  <= app_d;
            busy_q <= busy_d;
        end
    end

    assign applied = app_q;
    assign busy    = busy_q;

endmodule

// File: rtl/motor_ramp.sv
// Host command stage for the two-channel motor driver: ramps applied PWM toward targets and
// owns the driver write channel. Define MOTOR_RAMP_ESTOP_EN to add the estop input.
module motor_ramp
    import motor_pkg::*;
#(
    parameter int unsigned RAMP_DIV = 50000,
    parameter int unsigned STEP     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [TAG_W-1:0]  cmd_ctrl,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic              cmd_wr,
`ifdef MOTOR_RAMP_ESTOP_EN
    input  logic              estop,
`endif
    output logic [TAG_W-1:0]  motor_ctrl,
    output logic [DATA_W-1:0] motor_data,
    output logic              motor_wr,
    output logic              ramp_busy
);

    localparam int unsigned CNT_W = (RAMP_DIV > 2) ? $clog2(RAMP_DIV) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic             tick;
    logic             accept;
    logic             extra_wr;
    logic [TAG_W-1:0] tag_q;
    logic             wr_q;
    chan_t            app0, app1;
    logic             changed0, changed1;
    logic             busy0, busy1;

    assign tick = (cnt_q == CNT_W'(RAMP_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (tick)
            cnt_q <= '0;
        else
            cnt_q <= cnt_q + CNT_W'(1);
    end

`ifdef MOTOR_RAMP_ESTOP_EN
    logic estop_q;
    logic estop_rise;

    assign estop_rise = estop & ~estop_q;
    assign accept     = cmd_wr & (cmd_ctrl != TAG_OVF) & ~estop;
    assign extra_wr   = estop_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            estop_q <= 1'b0;
        else
            estop_q <= estop;
    end
`else
    assign accept   = cmd_wr & (cmd_ctrl != TAG_OVF);
    assign extra_wr = 1'b0;
`endif

    motor_ramp_chan #(.STEP(STEP)) u_chan0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick    (tick),
        .load    (accept),
        .target  (chan_t'(cmd_data[CH0_LSB +: CHAN_W])),
`ifdef MOTOR_RAMP_ESTOP_EN
        .clear   (estop),
`endif
        .applied (app0),
        .changed (changed0),
        .busy    (busy0)
    );

    motor_ramp_chan #(.STEP(STEP)) u_chan1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick    (tick),
        .load    (accept),
        .target  (chan_t'(cmd_data[CH1_LSB +: CHAN_W])),
`ifdef MOTOR_RAMP_ESTOP_EN
        .clear   (estop),
`endif
        .applied (app1),
        .changed (changed1),
        .busy    (busy1)
    );

    // Echo, ramp and estop events on one edge collapse into a single strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q <= '0;
            wr_q  <= 1'b0;
        end else begin
            if (extra_wr)
                tag_q <= '0;
            else if (accept)
                tag_q <= cmd_ctrl;
            wr_q <= accept | changed0 | changed1 | extra_wr;
        end
    end

    assign motor_ctrl                    = tag_q;
    assign motor_data[CH0_LSB +: CHAN_W] = app0;
    assign motor_data[CH1_LSB +: CHAN_W] = app1;
    assign motor_wr                      = wr_q;
    assign ramp_busy                     = busy0 | busy1;

endmodule
